// File: rtl/banked_regfile_seq_if.sv
// Bus bundle between decode/writeback, the load/store unit and the banked register file.
interface banked_regfile_seq_if #(
  parameter int SIZE   = 32,
  parameter int NUM_RD = 3
);
  logic [4:0]             M;
  logic [4*NUM_RD-1:0]    R_Addr;
  logic [SIZE*NUM_RD-1:0] R_Data;
  logic                   Write_Reg;
  logic [3:0]             W_Addr;
  logic [SIZE-1:0]        W_Data;
  logic                   Write_PC;
  logic [SIZE-1:0]        PC_New;
  logic                   PC_Inc;
  logic [SIZE-1:0]        PC;
  logic                   BT_Start;
  logic [15:0]            BT_List;
  logic                   BT_Load;
  logic                   BT_User;
  logic                   BT_Ready;
  logic [SIZE-1:0]        BT_Data_In;
  logic                   BT_Valid;
  logic [3:0]             BT_Addr;
  logic [SIZE-1:0]        BT_Data_Out;
  logic                   BT_Busy;
  logic                   BT_Done;
  logic                   Err;

  modport slave (
    input  M, R_Addr, Write_Reg, W_Addr, W_Data, Write_PC, PC_New, PC_Inc,
           BT_Start, BT_List, BT_Load, BT_User, BT_Ready, BT_Data_In,
    output R_Data, PC, BT_Valid, BT_Addr, BT_Data_Out, BT_Busy, BT_Done, Err
  );

  modport master (
    output M, R_Addr, Write_Reg, W_Addr, W_Data, Write_PC, PC_New, PC_Inc,
           BT_Start, BT_List, BT_Load, BT_User, BT_Ready, BT_Data_In,
    input  R_Data, PC, BT_Valid, BT_Addr, BT_Data_Out, BT_Busy, BT_Done, Err
  );
endinterface

// File: rtl/banked_regfile_seq.sv
// Mode-banked R0-R14 plus PC, multi-port reads with write bypass, and an LDM/STM-style
// block-transfer sequencer walking a 16-bit register list one beat per handshake.
module banked_regfile_seq #(
  parameter int SIZE    = 32,
  parameter int NUM_RD  = 3,
  parameter int PC_STEP = 4
) (
  input logic                 clk,
  input logic                 Rst_n,
  banked_regfile_seq_if.slave bus
);
  // state | meaning
  // IDLE  | no transfer, normal writes accepted
  // RUN   | one beat per BT_Ready, lowest remaining list bit first
  // DONE  | one-cycle BT_Done, writes still blocked
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam int              NPHYS    = 33;
  localparam logic [4:0]      MODE_USR = 5'b10000;
  localparam logic [SIZE-1:0] PC_INC_W = SIZE'(PC_STEP);

  function automatic logic mode_legal(input logic [4:0] m);
    case (m)
      5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110,
      5'b10111, 5'b11010, 5'b11011, 5'b11111: mode_legal = 1'b1;
      default:                                mode_legal = 1'b0;
    endcase
  endfunction

  // Physical layout: 0-14 base, 15-21 fiq R8-R14, 22..31 R13/R14 pairs, 32 hyp R13.
  function automatic logic [5:0] phys_idx(input logic [4:0] m, input logic [3:0] a);
    logic [5:0] base;
    logic       hi;
    base     = 6'd0;
    hi       = (a == 4'd14);
    phys_idx = {2'b00, a};
    if (m == 5'b10001 && a >= 4'd8) begin
      phys_idx = {2'b00, a} + 6'd7;
    end else if (a >= 4'd13) begin
      case (m)
        5'b10010: base = 6'd22;
        5'b10011: base = 6'd24;
        5'b10110: base = 6'd26;
        5'b10111: base = 6'd28;
        5'b11011: base = 6'd30;
        5'b11010: base = hi ? 6'd0 : 6'd32;
        default:  base = 6'd0;
      endcase
      if (base != 6'd0) phys_idx = base + {5'd0, hi};
    end
  endfunction

  state_t                 state_q, state_d;
  logic [15:0]            list_q, list_d;
  logic [4:0]             bank_q, bank_d;
  logic                   load_q, load_d;
  logic [SIZE-1:0]        pc_q, pc_d;
  logic                   err_q, err_d;
  logic [SIZE-1:0]        rf_q [NPHYS];
  logic [SIZE-1:0]        rf_d [NPHYS];

  logic                   m_legal, wr_ok, bt_fire, bt_pc_load, bt_start_err;
  logic [5:0]             w_idx, bt_idx;
  logic [3:0]             bt_addr, ra;
  logic [SIZE*NUM_RD-1:0] r_data;

  assign m_legal    = mode_legal(bus.M);
  assign w_idx      = phys_idx(bus.M, bus.W_Addr);
  assign wr_ok      = bus.Write_Reg && (bus.W_Addr != 4'hF) && m_legal && (state_q == S_IDLE);
  assign bt_idx     = phys_idx(bank_q, bt_addr);
  assign bt_fire    = (state_q == S_RUN) && bus.BT_Ready;
  assign bt_pc_load = bt_fire && load_q && (bt_addr == 4'hF);

  always_comb begin
    bt_addr = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) bt_addr = i[3:0];
    end
  end

  always_comb begin
    r_data = '0;
    ra     = 4'd0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = bus.R_Addr[4*k +: 4];
      if (ra == 4'hF)
        r_data[SIZE*k +: SIZE] = pc_q;
      else if (!m_legal && ra >= 4'd8)
        r_data[SIZE*k +: SIZE] = '0;
      else if (wr_ok && phys_idx(bus.M, ra) == w_idx)
        r_data[SIZE*k +: SIZE] = bus.W_Data;
      else
        r_data[SIZE*k +: SIZE] = rf_q[phys_idx(bus.M, ra)];
    end
  end

  always_comb begin
    state_d      = state_q;
    list_d       = list_q;
    bank_d       = bank_q;
    load_d       = load_q;
    rf_d         = rf_q;
    pc_d         = pc_q;
    bt_start_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.BT_Start) begin
          if (!m_legal && !bus.BT_User) begin
            bt_start_err = 1'b1;
          end else if (bus.BT_List == 16'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            list_d  = bus.BT_List;
            load_d  = bus.BT_Load;
            bank_d  = bus.BT_User ? MODE_USR : bus.M;
          end
        end
      end
      S_RUN: begin
        if (bus.BT_Ready) begin
          list_d = list_q & (list_q - 16'd1);
          if (list_d == 16'd0) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr_ok) rf_d[w_idx] = bus.W_Data;
    if (bt_fire && load_q && bt_addr != 4'hF) rf_d[bt_idx] = bus.BT_Data_In;

    if (bt_pc_load)        pc_d = bus.BT_Data_In;
    else if (bus.Write_PC) pc_d = bus.PC_New;
    else if (bus.PC_Inc)   pc_d = pc_q + PC_INC_W;

    // All error causes fold into one pulse.
    err_d = (bus.Write_Reg && !wr_ok) || bt_start_err;
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      list_q  <= '0;
      bank_q  <= '0;
      load_q  <= 1'b0;
      pc_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NPHYS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      bank_q  <= bank_d;
      load_q  <= load_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      for (int i = 0; i < NPHYS; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign bus.R_Data      = r_data;
  assign bus.PC          = pc_q;
  assign bus.BT_Valid    = (state_q == S_RUN);
  assign bus.BT_Addr     = bt_addr;
  assign bus.BT_Data_Out = (bt_addr == 4'hF) ? pc_q : rf_q[bt_idx];
  assign bus.BT_Busy     = (state_q != S_IDLE);
  assign bus.BT_Done     = (state_q == S_DONE);
  assign bus.Err         = err_q;
endmodule

// File: tb/tb_banked_regfile_seq.sv
// Self-checking bench: directed scenarios plus randomized traffic against a bank/register model.
module tb_banked_regfile_seq;
  localparam int SIZE    = 32;
  localparam int NUM_RD  = 3;
  localparam int PC_STEP = 4;

  localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010, SVC = 5'b10011;
  localparam logic [4:0] MON = 5'b10110, ABT = 5'b10111, HYP = 5'b11010, UND = 5'b11011;
  localparam logic [4:0] SYS = 5'b11111, BAD = 5'b01010;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  banked_regfile_seq_if #(.SIZE(SIZE), .NUM_RD(NUM_RD)) bus ();
  banked_regfile_seq #(.SIZE(SIZE), .NUM_RD(NUM_RD), .PC_STEP(PC_STEP)) dut (
    .clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // mdl[bank][reg]; banks: 0 usr/sys, 1 fiq, 2 irq, 3 svc, 4 mon, 5 abt, 6 und, 7 hyp
  logic [SIZE-1:0] mdl [8][15];
  logic [SIZE-1:0] mdl_pc;
  logic [4:0]      legal_modes [9] = '{USR, FIQ, IRQ, SVC, MON, ABT, HYP, UND, SYS};

  function automatic bit is_legal(logic [4:0] m);
    for (int i = 0; i < 9; i++) if (legal_modes[i] == m) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int bank_of(logic [4:0] m, int r);
    if (m == FIQ && r >= 8) return 1;
    if (r >= 13) begin
      case (m)
        IRQ: return 2;
        SVC: return 3;
        MON: return 4;
        ABT: return 5;
        UND: return 6;
        HYP: return (r == 13) ? 7 : 0;
        default: return 0;
      endcase
    end
    return 0;
  endfunction

  function automatic logic [SIZE-1:0] mdl_read(logic [4:0] m, int r);
    if (r == 15) return mdl_pc;
    if (!is_legal(m) && r >= 8) return '0;
    return mdl[bank_of(m, r)][r];
  endfunction

  function automatic logic [SIZE-1:0] port_data(int k);
    return bus.R_Data[SIZE*k +: SIZE];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.M = USR; bus.R_Addr = '0; bus.Write_Reg = 1'b0; bus.W_Addr = '0; bus.W_Data = '0;
    bus.Write_PC = 1'b0; bus.PC_New = '0; bus.PC_Inc = 1'b0; bus.BT_Start = 1'b0;
    bus.BT_List = '0; bus.BT_Load = 1'b0; bus.BT_User = 1'b0; bus.BT_Ready = 1'b0;
    bus.BT_Data_In = '0;
  endtask

  task automatic mdl_clear();
    for (int b = 0; b < 8; b++) for (int r = 0; r < 15; r++) mdl[b][r] = '0;
    mdl_pc = '0;
  endtask

  task automatic do_write(logic [4:0] m, int r, logic [SIZE-1:0] d);
    bus.M = m; bus.Write_Reg = 1'b1; bus.W_Addr = 4'(r); bus.W_Data = d;
    step();
    bus.Write_Reg = 1'b0;
    if (is_legal(m) && r != 15) mdl[bank_of(m, r)][r] = d;
  endtask

  task automatic set_pc(logic [SIZE-1:0] v);
    bus.Write_PC = 1'b1; bus.PC_New = v;
    step();
    bus.Write_PC = 1'b0;
    mdl_pc = v;
  endtask

  task automatic test_reset();
    drive_idle();
    mdl_clear();
    #1 rst_n = 1'b0;
    bus.R_Addr = {4'd15, 4'd13, 4'd0};
    #2;
    n_checks++; if (bus.PC !== '0) begin n_fail++; $display("FAIL reset_pc: got %h, expected 0", bus.PC); end
    n_checks++; if ({bus.Err, bus.BT_Valid, bus.BT_Busy, bus.BT_Done} !== 4'b0)
      begin n_fail++; $display("FAIL reset_flags: got %b, expected 0000", {bus.Err, bus.BT_Valid, bus.BT_Busy, bus.BT_Done}); end
    n_checks++; if (bus.R_Data !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h, expected 0", bus.R_Data); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.R_Addr = '0;
  endtask

  task automatic test_banking();
    do_write(SVC, 13, 32'h11);
    do_write(IRQ, 13, 32'h22);
    bus.R_Addr = {4'd0, 4'd0, 4'd13};
    bus.M = SVC; #1;
    n_checks++; if (port_data(0) !== 32'h11) begin n_fail++; $display("FAIL bank_svc_r13: got %h, expected 11", port_data(0)); end
    bus.M = IRQ; #1;
    n_checks++; if (port_data(0) !== 32'h22) begin n_fail++; $display("FAIL bank_irq_r13: got %h, expected 22", port_data(0)); end
    bus.M = USR; #1;
    n_checks++; if (port_data(0) !== 32'h0) begin n_fail++; $display("FAIL bank_usr_r13: got %h, expected 0", port_data(0)); end
    do_write(FIQ, 10, 32'hAB);
    bus.R_Addr = {4'd0, 4'd10, 4'd10};
    bus.M = USR; #1;
    n_checks++; if (port_data(0) !== 32'h0) begin n_fail++; $display("FAIL bank_usr_r10: got %h, expected 0", port_data(0)); end
    bus.M = FIQ; #1;
    n_checks++; if (port_data(1) !== 32'hAB) begin n_fail++; $display("FAIL bank_fiq_r10: got %h, expected ab", port_data(1)); end
    drive_idle();
  endtask

  task automatic test_bypass_pc();
    bus.M = USR; bus.R_Addr = {4'd0, 4'd0, 4'd3};
    bus.Write_Reg = 1'b1; bus.W_Addr = 4'd3; bus.W_Data = 32'hDEADBEEF;
    #1;
    n_checks++; if (port_data(0) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_r3: got %h, expected deadbeef", port_data(0)); end
    step();
    bus.Write_Reg = 1'b0;
    mdl[0][3] = 32'hDEADBEEF;
    #1;
    n_checks++; if (port_data(0) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored_r3: got %h, expected deadbeef", port_data(0)); end
    set_pc('0);
    for (int i = 0; i < 3; i++) begin bus.PC_Inc = 1'b1; step(); end
    bus.PC_Inc = 1'b0;
    n_checks++; if (bus.PC !== 32'd12) begin n_fail++; $display("FAIL pc_inc3: got %h, expected c", bus.PC); end
    bus.Write_PC = 1'b1; bus.PC_New = 32'h100; bus.PC_Inc = 1'b1;
    step();
    bus.Write_PC = 1'b0; bus.PC_Inc = 1'b0;
    n_checks++; if (bus.PC !== 32'h100) begin n_fail++; $display("FAIL pc_prio: got %h, expected 100", bus.PC); end
    set_pc(32'hFFFF_FFFC);
    bus.PC_Inc = 1'b1; step(); bus.PC_Inc = 1'b0;
    mdl_pc = '0;
    n_checks++; if (bus.PC !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %h, expected 0", bus.PC); end
    drive_idle();
  endtask

  task automatic test_errors();
    set_pc(32'h80);
    bus.Write_Reg = 1'b1; bus.W_Addr = 4'd15; bus.W_Data = 32'h55;
    step();
    bus.Write_Reg = 1'b0;
    n_checks++; if (bus.Err !== 1'b1) begin n_fail++; $display("FAIL err_r15: got %b, expected 1", bus.Err); end
    n_checks++; if (bus.PC !== 32'h80) begin n_fail++; $display("FAIL err_r15_pc: got %h, expected 80", bus.PC); end
    step();
    n_checks++; if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b, expected 0", bus.Err); end
    bus.M = BAD; bus.Write_Reg = 1'b1; bus.W_Addr = 4'd0; bus.W_Data = 32'h77;
    step();
    bus.Write_Reg = 1'b0; bus.M = USR; bus.R_Addr = '0;
    #1;
    n_checks++; if (bus.Err !== 1'b1) begin n_fail++; $display("FAIL err_mode: got %b, expected 1", bus.Err); end
    n_checks++; if (port_data(0) !== mdl[0][0]) begin n_fail++; $display("FAIL err_mode_r0: got %h, expected %h", port_data(0), mdl[0][0]); end
    bus.M = BAD; bus.BT_Start = 1'b1; bus.BT_List = 16'h0001; bus.BT_User = 1'b0;
    step();
    bus.BT_Start = 1'b0; bus.M = USR;
    n_checks++; if ({bus.Err, bus.BT_Busy} !== 2'b10) begin n_fail++; $display("FAIL err_bt_mode: got %b, expected 10", {bus.Err, bus.BT_Busy}); end
    bus.BT_Start = 1'b1; bus.BT_List = 16'h0002; bus.BT_Load = 1'b0; bus.BT_Ready = 1'b0;
    step();
    bus.BT_Start = 1'b0;
    bus.Write_Reg = 1'b1; bus.W_Addr = 4'd2; bus.W_Data = 32'h99;
    step();
    bus.Write_Reg = 1'b0;
    n_checks++; if (bus.Err !== 1'b1) begin n_fail++; $display("FAIL err_busy: got %b, expected 1", bus.Err); end
    bus.BT_Ready = 1'b1; step(); bus.BT_Ready = 1'b0; step();
    bus.R_Addr = {4'd0, 4'd0, 4'd2}; #1;
    n_checks++; if (port_data(0) !== mdl[0][2]) begin n_fail++; $display("FAIL err_busy_r2: got %h, expected %h", port_data(0), mdl[0][2]); end
    n_checks++; if (bus.BT_Busy !== 1'b0) begin n_fail++; $display("FAIL err_busy_idle: got %b, expected 0", bus.BT_Busy); end
    drive_idle();
  endtask

  task automatic test_store();
    logic [3:0]      e_addr [3];
    logic [SIZE-1:0] e_data [3];
    e_addr = '{4'd1, 4'd4, 4'd15};
    e_data = '{32'h1, 32'h4, 32'h40};
    do_write(USR, 1, 32'h1);
    do_write(USR, 4, 32'h4);
    set_pc(32'h40);
    bus.BT_Start = 1'b1; bus.BT_List = 16'h8012; bus.BT_Load = 1'b0; bus.BT_Ready = 1'b1;
    step();
    bus.BT_Start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if ({bus.BT_Valid, bus.BT_Done, bus.BT_Addr} !== {2'b10, e_addr[c]})
        begin n_fail++; $display("FAIL store_beat%0d: got v/d/addr %b/%b/%0d, expected 1/0/%0d", c, bus.BT_Valid, bus.BT_Done, bus.BT_Addr, e_addr[c]); end
      n_checks++; if (bus.BT_Data_Out !== e_data[c])
        begin n_fail++; $display("FAIL store_data%0d: got %h, expected %h", c, bus.BT_Data_Out, e_data[c]); end
      step();
    end
    #1;
    n_checks++; if ({bus.BT_Done, bus.BT_Valid, bus.BT_Busy} !== 3'b101)
      begin n_fail++; $display("FAIL store_done: got d/v/b %b, expected 101", {bus.BT_Done, bus.BT_Valid, bus.BT_Busy}); end
    bus.BT_Ready = 1'b0;
    step();
    n_checks++; if ({bus.BT_Done, bus.BT_Busy} !== 2'b00) begin n_fail++; $display("FAIL store_idle: got %b, expected 00", {bus.BT_Done, bus.BT_Busy}); end
    drive_idle();
  endtask

  task automatic test_random_rw();
    logic [4:0]      m;
    logic [SIZE-1:0] wd, pnew, exp;
    bit              we, acc, wpc, pinc;
    int              wa;
    int              ra [3];
    for (int it = 0; it < 150; it++) begin
      m    = ($urandom_range(0, 9) == 0) ? BAD : legal_modes[$urandom_range(0, 8)];
      we   = 1'($urandom_range(0, 1));
      wa   = $urandom_range(0, 15);
      wd   = $urandom;
      wpc  = ($urandom_range(0, 7) == 0);
      pinc = 1'($urandom_range(0, 1));
      pnew = $urandom;
      for (int k = 0; k < 3; k++) ra[k] = $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0) ra[0] = wa;
      bus.M = m; bus.Write_Reg = we; bus.W_Addr = 4'(wa); bus.W_Data = wd;
      bus.Write_PC = wpc; bus.PC_New = pnew; bus.PC_Inc = pinc;
      for (int k = 0; k < 3; k++) bus.R_Addr[4*k +: 4] = 4'(ra[k]);
      #1;
      acc = we && (wa != 15) && is_legal(m);
      for (int k = 0; k < 3; k++) begin
        exp = (acc && ra[k] == wa) ? wd : mdl_read(m, ra[k]);
        n_checks++; if (port_data(k) !== exp)
          begin n_fail++; $display("FAIL rand_read it%0d port%0d mode %b r%0d: got %h, expected %h", it, k, m, ra[k], port_data(k), exp); end
      end
      step();
      if (acc) mdl[bank_of(m, wa)][wa] = wd;
      if (wpc) mdl_pc = pnew;
      else if (pinc) mdl_pc = mdl_pc + PC_STEP;
      n_checks++; if (bus.Err !== (we && !acc)) begin n_fail++; $display("FAIL rand_err it%0d: got %b, expected %b", it, bus.Err, we && !acc); end
      n_checks++; if (bus.PC !== mdl_pc) begin n_fail++; $display("FAIL rand_pc it%0d: got %h, expected %h", it, bus.PC, mdl_pc); end
    end
    drive_idle();
  endtask

  task automatic test_load_stall();
    bit         rdy_seq  [4];
    logic [3:0] addr_seq [4];
    rdy_seq  = '{1'b0, 1'b1, 1'b0, 1'b1};
    addr_seq = '{4'd0, 4'd0, 4'd1, 4'd1};
    bus.M = FIQ; bus.BT_Start = 1'b1; bus.BT_List = 16'h0003; bus.BT_Load = 1'b1; bus.BT_User = 1'b1;
    step();
    bus.BT_Start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.BT_Ready = rdy_seq[c];
      bus.BT_Data_In = 32'hA0 + 32'(addr_seq[c]);
      #1;
      n_checks++; if ({bus.BT_Valid, bus.BT_Addr} !== {1'b1, addr_seq[c]})
        begin n_fail++; $display("FAIL stall_beat%0d: got v/addr %b/%0d, expected 1/%0d", c, bus.BT_Valid, bus.BT_Addr, addr_seq[c]); end
      step();
    end
    mdl[0][0] = 32'hA0; mdl[0][1] = 32'hA1;
    bus.BT_Ready = 1'b0; #1;
    n_checks++; if (bus.BT_Done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b, expected 1", bus.BT_Done); end
    step();
    bus.M = USR; bus.R_Addr = {4'd0, 4'd1, 4'd0}; #1;
    n_checks++; if (port_data(0) !== 32'hA0) begin n_fail++; $display("FAIL stall_r0: got %h, expected a0", port_data(0)); end
    n_checks++; if (port_data(1) !== 32'hA1) begin n_fail++; $display("FAIL stall_r1: got %h, expected a1", port_data(1)); end
    bus.BT_Start = 1'b1; bus.BT_List = 16'h8000; bus.BT_Load = 1'b1; bus.BT_User = 1'b0;
    step();
    bus.BT_Start = 1'b0; bus.BT_Ready = 1'b1; bus.BT_Data_In = 32'hCAFE0000;
    bus.Write_PC = 1'b1; bus.PC_New = 32'h1234;
    step();
    bus.Write_PC = 1'b0; bus.BT_Ready = 1'b0;
    mdl_pc = 32'hCAFE0000;
    n_checks++; if (bus.PC !== 32'hCAFE0000) begin n_fail++; $display("FAIL load_pc_prio: got %h, expected cafe0000", bus.PC); end
    step();
    drive_idle();
  endtask

  task automatic test_random_transfer();
    logic [15:0]     list;
    logic [4:0]      m, bank_m;
    logic [SIZE-1:0] din;
    bit              load, user, rdy;
    int              q [$];
    int              cycles;
    for (int t = 0; t < 10; t++) begin
      list   = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      load   = 1'($urandom_range(0, 1));
      user   = 1'($urandom_range(0, 1));
      m      = legal_modes[$urandom_range(0, 8)];
      bank_m = user ? USR : m;
      q.delete();
      for (int i = 0; i < 16; i++) if (list[i]) q.push_back(i);
      bus.M = m; bus.BT_Start = 1'b1; bus.BT_List = list; bus.BT_Load = load; bus.BT_User = user;
      step();
      bus.BT_Start = 1'b0;
      cycles = 0;
      while (q.size() > 0 && cycles < 200) begin
        rdy = ($urandom_range(0, 2) != 0);
        din = $urandom;
        bus.M = legal_modes[$urandom_range(0, 8)];
        bus.BT_Ready = rdy; bus.BT_Data_In = din;
        #1;
        n_checks++; if ({bus.BT_Valid, bus.BT_Addr} !== {1'b1, 4'(q[0])})
          begin n_fail++; $display("FAIL xfer%0d_addr: got v/addr %b/%0d, expected 1/%0d", t, bus.BT_Valid, bus.BT_Addr, q[0]); end
        if (!load) begin
          n_checks++; if (bus.BT_Data_Out !== mdl_read(bank_m, q[0]))
            begin n_fail++; $display("FAIL xfer%0d_data r%0d: got %h, expected %h", t, q[0], bus.BT_Data_Out, mdl_read(bank_m, q[0])); end
        end
        step();
        if (rdy) begin
          if (load) begin
            if (q[0] == 15) mdl_pc = din;
            else mdl[bank_of(bank_m, q[0])][q[0]] = din;
          end
          void'(q.pop_front());
        end
        cycles++;
      end
      n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL xfer%0d_timeout: got %0d beats left, expected 0", t, q.size()); end
      bus.BT_Ready = 1'b0; #1;
      n_checks++; if ({bus.BT_Done, bus.BT_Valid} !== 2'b10)
        begin n_fail++; $display("FAIL xfer%0d_done: got d/v %b, expected 10", t, {bus.BT_Done, bus.BT_Valid}); end
      step();
      n_checks++; if ({bus.BT_Done, bus.BT_Busy} !== 2'b00)
        begin n_fail++; $display("FAIL xfer%0d_idle: got %b, expected 00", t, {bus.BT_Done, bus.BT_Busy}); end
    end
    for (int mi = 0; mi < 9; mi++) begin
      for (int r = 0; r < 16; r++) begin
        bus.M = legal_modes[mi]; bus.R_Addr = {8'd0, 4'(r)}; #1;
        n_checks++; if (port_data(0) !== mdl_read(legal_modes[mi], r))
          begin n_fail++; $display("FAIL sweep mode %b r%0d: got %h, expected %h", legal_modes[mi], r, port_data(0), mdl_read(legal_modes[mi], r)); end
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    bus.M = USR; bus.BT_Start = 1'b1; bus.BT_List = 16'h00F0; bus.BT_Load = 1'b1; bus.BT_Ready = 1'b1;
    bus.BT_Data_In = 32'h1357_9BDF;
    step();
    bus.BT_Start = 1'b0;
    step();
    #2 rst_n = 1'b0;
    bus.R_Addr = {4'd15, 4'd5, 4'd4};
    #1;
    mdl_clear();
    n_checks++; if ({bus.BT_Valid, bus.BT_Busy, bus.BT_Done, bus.Err} !== 4'b0)
      begin n_fail++; $display("FAIL rstmid_flags: got %b, expected 0000", {bus.BT_Valid, bus.BT_Busy, bus.BT_Done, bus.Err}); end
    n_checks++; if ({bus.PC, bus.BT_Addr, bus.BT_Data_Out} !== '0)
      begin n_fail++; $display("FAIL rstmid_pc_bt: got pc %h addr %0d data %h, expected 0", bus.PC, bus.BT_Addr, bus.BT_Data_Out); end
    n_checks++; if (bus.R_Data !== '0) begin n_fail++; $display("FAIL rstmid_rdata: got %h, expected 0", bus.R_Data); end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++; if (bus.BT_Busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b, expected 0", bus.BT_Busy); end
    bus.BT_Start = 1'b1; bus.BT_List = 16'h0;
    step();
    bus.BT_Start = 1'b0; #1;
    n_checks++; if ({bus.BT_Done, bus.BT_Valid} !== 2'b10) begin n_fail++; $display("FAIL empty_done: got d/v %b, expected 10", {bus.BT_Done, bus.BT_Valid}); end
    step();
    n_checks++; if (bus.BT_Done !== 1'b0) begin n_fail++; $display("FAIL empty_done_pulse: got %b, expected 0", bus.BT_Done); end
  endtask

  initial begin
    test_reset();
    test_banking();
    test_bypass_pc();
    test_errors();
    test_store();
    test_random_rw();
    test_load_stall();
    test_random_transfer();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
